// File: rtl/riesgos_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package riesgos_pkg;

    typedef enum logic [1:0] {
        RUN,
        STALL_LOAD,
        WAIT_MEM,
        FLUSH
    } estado_t;

    localparam int REG_AW = 4;

    // Instruction word injected into Decode->Execute while NOP_Mux is high (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_en;
        logic f_en;
        logic d_en;
        logic x_en;
        logic nop_mux;
        logic flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, f_en: 1'b1, d_en: 1'b1, x_en: 1'b1, nop_mux: 1'b0, flush: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, f_en: 1'b0, d_en: 1'b0, x_en: 1'b0, nop_mux: 1'b0, flush: 1'b0};
    localparam ctrl_t CTRL_STALL  = '{pc_en: 1'b0, f_en: 1'b0, d_en: 1'b1, x_en: 1'b1, nop_mux: 1'b1, flush: 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, f_en: 1'b1, d_en: 1'b1, x_en: 1'b1, nop_mux: 1'b0, flush: 1'b1};
    localparam ctrl_t CTRL_RESET  = '{pc_en: 1'b0, f_en: 1'b0, d_en: 1'b0, x_en: 1'b0, nop_mux: 1'b1, flush: 1'b0};

endpackage

// File: rtl/control_riesgos_if.sv
// Pipeline-side bundle of the hazard controller: hazard sources in, enables and controls out.
interface control_riesgos_if;
    import riesgos_pkg::*;

    logic [REG_AW-1:0] Ra_F_Exe;
    logic              RE_A_F_Exe;
    logic [REG_AW-1:0] Rb_F_Exe;
    logic              RE_B_F_Exe;
    logic [REG_AW-1:0] Robj_Reg_Exe;
    logic              mem_RE_Reg_Exe;
    logic              mem_req;
    logic              mem_ack;
    logic              branch_taken;
    logic              PC_EN;
    logic              F_Reg_EN;
    logic              D_Reg_EN;
    logic              X_Reg_EN;
    logic              NOP_Mux;
    logic              flush;
    logic              mem_timeout;

    modport master (
        output Ra_F_Exe, RE_A_F_Exe, Rb_F_Exe, RE_B_F_Exe, Robj_Reg_Exe, mem_RE_Reg_Exe,
        output mem_req, mem_ack, branch_taken,
        input  PC_EN, F_Reg_EN, D_Reg_EN, X_Reg_EN, NOP_Mux, flush, mem_timeout
    );

    modport slave (
        input  Ra_F_Exe, RE_A_F_Exe, Rb_F_Exe, RE_B_F_Exe, Robj_Reg_Exe, mem_RE_Reg_Exe,
        input  mem_req, mem_ack, branch_taken,
        output PC_EN, F_Reg_EN, D_Reg_EN, X_Reg_EN, NOP_Mux, flush, mem_timeout
    );

endinterface

// File: rtl/comparador_riesgo.sv
// Combinational load-use compare between the Decode sources and the load destination in Execute.
module comparador_riesgo
    import riesgos_pkg::*;
(
    input  logic [REG_AW-1:0] ra,
    input  logic              re_a,
    input  logic [REG_AW-1:0] rb,
    input  logic              re_b,
    input  logic [REG_AW-1:0] robj,
    input  logic              mem_re,
    output logic              hazard
);

    assign hazard = mem_re && ((re_a && (ra == robj)) || (re_b && (rb == robj)));

endmodule

// File: rtl/control_riesgos.sv
// Pipeline hazard/stall controller: load-use bubbles, memory waits and branch flushes.
// Optional memory-wait timeout is built when RIESGO_TIMEOUT_EN is defined.
module control_riesgos
    import riesgos_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 15
) (
    input logic               clk,
    input logic               rst,
    control_riesgos_if.slave  bus
);

    if (LOAD_LAT < 1 || LOAD_LAT > 3 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_param_check
        $error("control_riesgos: LOAD_LAT or MAX_WAIT out of range");
    end

    estado_t    state, state_next;
    logic [1:0] stall_cnt, stall_cnt_next;
    logic       hazard;
    logic       mem_wait;
    ctrl_t      ctrl;

    comparador_riesgo u_comparador (
        .ra     (bus.Ra_F_Exe),
        .re_a   (bus.RE_A_F_Exe),
        .rb     (bus.Rb_F_Exe),
        .re_b   (bus.RE_B_F_Exe),
        .robj   (bus.Robj_Reg_Exe),
        .mem_re (bus.mem_RE_Reg_Exe),
        .hazard (hazard)
    );

    assign mem_wait = bus.mem_req && !bus.mem_ack;

`ifdef RIESGO_TIMEOUT_EN
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       timeout_q, timeout_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.mem_timeout = timeout_q;
`else
    assign bus.mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        ctrl           = CTRL_RUN;
`ifdef RIESGO_TIMEOUT_EN
        wait_cnt_next  = wait_cnt;
        timeout_set    = 1'b0;
`endif
        case (state)
            RUN: begin
                if (mem_wait) begin
                    ctrl       = CTRL_FREEZE;
                    state_next = WAIT_MEM;
`ifdef RIESGO_TIMEOUT_EN
                    wait_cnt_next = 8'd1;
`endif
                end else if (bus.branch_taken) begin
                    ctrl       = CTRL_BRANCH;
                    state_next = FLUSH;
                end else if (hazard) begin
                    ctrl = CTRL_STALL;
                    if (LOAD_LAT > 1) begin
                        state_next     = STALL_LOAD;
                        stall_cnt_next = 2'(LOAD_LAT - 1);
                    end
                end
            end
            STALL_LOAD: begin
                // A memory wait abandons whatever bubble cycles remain
                if (mem_wait) begin
                    ctrl           = CTRL_FREEZE;
                    state_next     = WAIT_MEM;
                    stall_cnt_next = 2'd0;
`ifdef RIESGO_TIMEOUT_EN
                    wait_cnt_next  = 8'd1;
`endif
                end else begin
                    ctrl = CTRL_STALL;
                    if (stall_cnt == 2'd1) begin
                        state_next     = RUN;
                        stall_cnt_next = 2'd0;
                    end else begin
                        stall_cnt_next = stall_cnt - 2'd1;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_ack) begin
                    ctrl       = CTRL_RUN;
                    state_next = RUN;
`ifdef RIESGO_TIMEOUT_EN
                    wait_cnt_next = 8'd0;
`endif
                end else begin
                    ctrl = CTRL_FREEZE;
`ifdef RIESGO_TIMEOUT_EN
                    if (wait_cnt == 8'(MAX_WAIT)) begin
                        timeout_set   = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = 8'd0;
                    end else begin
                        wait_cnt_next = wait_cnt + 8'd1;
                    end
`endif
                end
            end
            FLUSH: begin
                // Decode holds a squashed slot, so its hazard is not acted on
                if (mem_wait) begin
                    ctrl       = CTRL_FREEZE;
                    state_next = WAIT_MEM;
`ifdef RIESGO_TIMEOUT_EN
                    wait_cnt_next = 8'd1;
`endif
                end else begin
                    ctrl       = CTRL_RUN;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    assign bus.PC_EN    = ctrl.pc_en;
    assign bus.F_Reg_EN = ctrl.f_en;
    assign bus.D_Reg_EN = ctrl.d_en;
    assign bus.X_Reg_EN = ctrl.x_en;
    assign bus.NOP_Mux  = ctrl.nop_mux;
    assign bus.flush    = ctrl.flush;

endmodule

// File: tb/tb_control_riesgos.sv
// Self-checking bench for control_riesgos: two instances (LOAD_LAT 1 and 3) against a cycle model.
module tb_control_riesgos;

    localparam int MAX_WAIT = 15;

    localparam logic [5:0] E_RUN    = 6'b111100;
    localparam logic [5:0] E_FREEZE = 6'b000000;
    localparam logic [5:0] E_STALL  = 6'b001110;
    localparam logic [5:0] E_BRANCH = 6'b111101;
    localparam logic [5:0] E_RESET  = 6'b000010;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    control_riesgos_if bus1 ();
    control_riesgos_if bus3 ();

    control_riesgos #(.LOAD_LAT(1), .MAX_WAIT(MAX_WAIT)) u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
    control_riesgos #(.LOAD_LAT(3), .MAX_WAIT(MAX_WAIT)) u_lat3 (.clk(clk), .rst(rst), .bus(bus3));

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] cur_ra, cur_rb, cur_robj;
    logic       cur_rea, cur_reb, cur_memre, cur_req, cur_ack, cur_br;

    // Reference model per instance: bubble cycles still owed, pending memory wait, squashed Decode slot
    int lat[2]      = '{1, 3};
    int hold[2]     = '{0, 0};
    int wcnt[2]     = '{0, 0};
    bit waiting[2]  = '{0, 0};
    bit squashed[2] = '{0, 0};
    bit tmo[2]      = '{0, 0};

    task automatic applyStimulus(input logic [3:0] ra, input logic rea, input logic [3:0] rb,
                                 input logic reb, input logic [3:0] robj, input logic memre,
                                 input logic req, input logic ack, input logic br);
        cur_ra = ra; cur_rea = rea; cur_rb = rb; cur_reb = reb; cur_robj = robj;
        cur_memre = memre; cur_req = req; cur_ack = ack; cur_br = br;
        bus1.Ra_F_Exe = ra; bus1.RE_A_F_Exe = rea; bus1.Rb_F_Exe = rb; bus1.RE_B_F_Exe = reb;
        bus1.Robj_Reg_Exe = robj; bus1.mem_RE_Reg_Exe = memre;
        bus1.mem_req = req; bus1.mem_ack = ack; bus1.branch_taken = br;
        bus3.Ra_F_Exe = ra; bus3.RE_A_F_Exe = rea; bus3.Rb_F_Exe = rb; bus3.RE_B_F_Exe = reb;
        bus3.Robj_Reg_Exe = robj; bus3.mem_RE_Reg_Exe = memre;
        bus3.mem_req = req; bus3.mem_ack = ack; bus3.branch_taken = br;
    endtask

    task automatic idle();
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Checks one cycle at the falling edge, advances the model, then returns just after the rising edge
    task automatic checkOutput(input string tag);
        logic [6:0] exp_v, obs_v;
        logic [5:0] ctl;
        bit         haz, wnow, tmo_now;
        @(negedge clk);
        haz  = cur_memre && ((cur_rea && cur_ra == cur_robj) || (cur_reb && cur_rb == cur_robj));
        wnow = cur_req && !cur_ack;
        for (int d = 0; d < 2; d++) begin
            tmo_now = tmo[d];
            if (rst) begin
                ctl = E_RESET;
                hold[d] = 0; wcnt[d] = 0; waiting[d] = 0; squashed[d] = 0; tmo[d] = 0;
                tmo_now = 0;
            end else if (waiting[d]) begin
                if (cur_ack) begin
                    ctl = E_RUN;
                    waiting[d] = 0;
                end else begin
                    ctl = E_FREEZE;
`ifdef RIESGO_TIMEOUT_EN
                    if (wcnt[d] == MAX_WAIT) begin
                        tmo[d] = 1;
                        waiting[d] = 0;
                    end else begin
                        wcnt[d]++;
                    end
`endif
                end
            end else if (wnow) begin
                ctl = E_FREEZE;
                waiting[d] = 1; wcnt[d] = 1; hold[d] = 0; squashed[d] = 0;
            end else if (hold[d] > 0) begin
                ctl = E_STALL;
                hold[d]--;
            end else if (squashed[d]) begin
                ctl = E_RUN;
                squashed[d] = 0;
            end else if (cur_br) begin
                ctl = E_BRANCH;
                squashed[d] = 1;
            end else if (haz) begin
                ctl = E_STALL;
                hold[d] = lat[d] - 1;
            end else begin
                ctl = E_RUN;
            end
            exp_v = {ctl, tmo_now};
            if (d == 0)
                obs_v = {bus1.PC_EN, bus1.F_Reg_EN, bus1.D_Reg_EN, bus1.X_Reg_EN,
                         bus1.NOP_Mux, bus1.flush, bus1.mem_timeout};
            else
                obs_v = {bus3.PC_EN, bus3.F_Reg_EN, bus3.D_Reg_EN, bus3.X_Reg_EN,
                         bus3.NOP_Mux, bus3.flush, bus3.mem_timeout};
            n_cmp++;
            assert (obs_v === exp_v) else begin
                n_bad++;
                $error("[TB] FAIL %s lat%0d: observed PC/F/D/X/NOP/flush/tmo=%b expected %b",
                       tag, lat[d], obs_v, exp_v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        checkOutput("reset0");
        checkOutput("reset1");
        rst = 1'b0;
        checkOutput("first_run");

        // Load into r3, next instruction reads r3 on A
        applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hazA");
        idle();
        repeat (3) checkOutput("hazA_after");

        // Same registers, A not read
        applyStimulus(4'd3, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("noread_A");

        // Hazard on B (r7)
        applyStimulus(4'd1, 1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hazB");
        idle();
        repeat (3) checkOutput("hazB_after");

        // Memory wait acknowledged on the fifth cycle
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) checkOutput("memwait");
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("memack");
        idle();
        checkOutput("after_ack");

        // Branch and hazard together, hazard still visible during the flush cycle
        applyStimulus(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("branch_haz");
        applyStimulus(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_cycle");
        idle();
        checkOutput("after_flush");

        // Long wait with no ack; sticky timeout when the feature is built
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (MAX_WAIT + 3) checkOutput("noack");
        idle();
        repeat (4) checkOutput("timeout_sticky");

        // Reset in the middle of a wait
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) checkOutput("pre_rst_wait");
        rst = 1'b1;
        checkOutput("rst_in_wait");
        idle();
        checkOutput("rst_held");
        rst = 1'b0;
        checkOutput("post_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 7) == 0));
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_riesgos.md
# control_riesgos

Pipeline hazard and stall controller for the filter processor core. Each cycle it combines three inputs into one set of pipeline register enables, bubble-insert and flush controls: load-use detection between the Decode and Execute stages, the variable-latency memory handshake from the Memory stage, and taken-branch resolution from Execute. A small FSM holds multi-cycle stalls and memory waits. It sits beside the PC and the F/D/X pipeline registers and is their only source of enables.

## Interface
- LOAD_LAT, 1: bubble cycles inserted per load-use hazard (1..3)
- MAX_WAIT, 15: memory wait cycles before timeout (1..255)

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- Ra_F_Exe  in  4  source A register of the instruction in Decode
- RE_A_F_Exe  in  1  source A is read
- Rb_F_Exe  in  4  source B register of the instruction in Decode
- RE_B_F_Exe  in  1  source B is read
- Robj_Reg_Exe  in  4  destination register of the instruction in Execute
- mem_RE_Reg_Exe  in  1  instruction in Execute is a load
- mem_req  in  1  Memory stage access in progress
- mem_ack  in  1  memory access completes this cycle
- branch_taken  in  1  taken branch resolved in Execute
- PC_EN  out  1  PC update enable
- F_Reg_EN  out  1  Fetch→Decode register enable
- D_Reg_EN  out  1  Decode→Execute register enable
- X_Reg_EN  out  1  Execute→Memory register enable
- NOP_Mux  out  1  selects NOP into the Decode→Execute register
- flush  out  1  synchronous clear of the F and D registers
- mem_timeout  out  1  sticky error flag for a memory wait timeout

## Operation
- States: RUN, STALL_LOAD, WAIT_MEM, FLUSH. Outputs are Mealy: state plus current inputs.
- hazard = mem_RE_Reg_Exe && ((RE_A_F_Exe && Ra_F_Exe==Robj_Reg_Exe) || (RE_B_F_Exe && Rb_F_Exe==Robj_Reg_Exe)).
- Priority in RUN: memory wait > branch > hazard.
- RUN with mem_req && !mem_ack: all four enables 0, NOP_Mux 0, flush 0. Next state WAIT_MEM, wait counter = 1.
- RUN with branch_taken: enables 1, flush 1, NOP_Mux 0. Next state FLUSH.
- RUN with hazard: PC_EN 0, F_Reg_EN 0, D_Reg_EN 1, X_Reg_EN 1, NOP_Mux 1. Next state STALL_LOAD with stall counter = LOAD_LAT−1 if LOAD_LAT>1; otherwise stay in RUN.
- RUN with no event: all enables 1, NOP_Mux 0, flush 0.
- STALL_LOAD: same outputs as the hazard case. Hazard inputs are ignored. The counter decrements each cycle, and the state returns to RUN when the counter is 1. A mem_req && !mem_ack overrides: go to WAIT_MEM, and the remaining stall is dropped.
- WAIT_MEM: full freeze. mem_ack → RUN in the next cycle; enables return to 1 in the same cycle as mem_ack. With timeout compiled in, counter == MAX_WAIT without ack → mem_timeout set, RUN.
- FLUSH: lasts one cycle. Enables 1, flush 0, hazard suppressed because Decode holds a squashed slot. A new memory wait overrides the flush. Next state RUN.
- branch_taken during a freeze is held stable by the frozen pipeline and is acted on in RUN.
- mem_timeout is cleared only by rst.

## Timing
- Hazard response is combinational in the same cycle as detection; there is zero latency from inputs to outputs.
- A load-use hazard costs exactly LOAD_LAT cycles of PC/F hold.
- A memory wait costs the number of cycles from mem_req to mem_ack inclusive, minus 1.
- While rst is high: state RUN, all counters 0, mem_timeout 0, PC_EN/F_Reg_EN/D_Reg_EN/X_Reg_EN 0, NOP_Mux 1, flush 0. A reset in the middle of any stall or wait aborts it immediately.
- First cycle after rst falls: normal RUN behaviour.

## Configuration
- RIESGO_TIMEOUT_EN defined: an 8-bit wait counter is built and a timeout exits WAIT_MEM as described under Operation.
- RIESGO_TIMEOUT_EN undefined: WAIT_MEM exits only on mem_ack, and mem_timeout is tied to 0.

## Structure
- Package riesgos_pkg holds:
  - the state enum (RUN, STALL_LOAD, WAIT_MEM, FLUSH)
  - REG_AW = 4
  - the NOP encoding constant
- Sub-module comparador_riesgo: purely combinational load-use compare that produces hazard. It is instantiated once.
- Top level holds the FSM, the stall counter, the wait counter and the output decode.

## Test plan
- Load into r3 followed by an instruction reading r3 on A, LOAD_LAT=1 → one cycle with PC_EN=0, F_Reg_EN=0, NOP_Mux=1, then normal flow. Same case with RE_A_F_Exe=0 → no stall.
- LOAD_LAT=3, hazard on B (r7) → PC_EN low for exactly 3 cycles, NOP_Mux high for 3 cycles.
- mem_req high with mem_ack arriving after 4 cycles → all enables 0 for 4 cycles, then 1 in the ack cycle.
- branch_taken and hazard in the same cycle → flush=1, NOP_Mux=0, PC_EN=1, then one FLUSH cycle with no stall.
- RIESGO_TIMEOUT_EN, MAX_WAIT=15, no ack → mem_timeout rises after 15 wait cycles and stays high until rst.
- rst asserted during WAIT_MEM and then released → outputs at reset values while rst is high, RUN with all enables 1 in the next cycle.
